// File: rtl/noise_arbiter.sv
// Round-robin arbiter that shares one 16-bit Fibonacci LFSR noise source among
// NUM_REQ requesters, streaming each granted burst over a valid/ready handshake.
module noise_arbiter #(
  parameter int          NUM_REQ = 4,
  parameter int          LEN_W   = 8,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*LEN_W-1:0] req_len,
  input  logic                     seed_load,
  input  logic [15:0]              seed_val,
  input  logic                     noise_ready,
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     noise_valid,
  output logic [15:0]              noise_data,
  output logic                     noise_last,
  output logic                     busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {IDLE, STREAM} state_t;

  state_t               state, state_next;
  logic [15:0]          lfsr, lfsr_next;
  logic [LEN_W-1:0]     cnt, cnt_next;
  logic [PTR_W-1:0]     ptr, ptr_next;
  logic [NUM_REQ-1:0]   gnt_q, gnt_next;

  logic [LEN_W-1:0]     len_arr [NUM_REQ];
  logic                 found;
  logic [PTR_W-1:0]     win;
  logic [PTR_W-1:0]     cand;
  logic                 feedback;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_len
    assign len_arr[g] = req_len[g*LEN_W +: LEN_W];
  end

  assign feedback = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  // Search starts just past the last winner, so each requester waits at most
  // NUM_REQ-1 bursts.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = PTR_W'((int'(ptr) + i) % NUM_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // NOTE: every next-state variable takes its current value first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    lfsr_next  = lfsr;
    cnt_next   = cnt;
    ptr_next   = ptr;
    gnt_next   = gnt_q;
    unique case (state)
      IDLE: begin
        if (seed_load) begin
          lfsr_next = (seed_val == 16'h0) ? SEED : seed_val;
        end else if (found) begin
          cnt_next      = len_arr[win];
          gnt_next      = '0;
          gnt_next[win] = 1'b1;
          ptr_next      = win;
          state_next    = STREAM;
        end
      end
      STREAM: begin
        if (noise_ready) begin
          lfsr_next = {lfsr[14:0], feedback};
          if (cnt == '0) begin
            gnt_next   = '0;
            state_next = IDLE;
          end else begin
            cnt_next = cnt - LEN_W'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      lfsr  <= SEED;
      cnt   <= '0;
      ptr   <= PTR_W'(NUM_REQ - 1);
      gnt_q <= '0;
    end else begin
      state <= state_next;
      lfsr  <= lfsr_next;
      cnt   <= cnt_next;
      ptr   <= ptr_next;
      gnt_q <= gnt_next;
    end
  end

  assign gnt         = gnt_q;
  assign busy        = (state == STREAM);
  assign noise_valid = busy;
  assign noise_last  = busy && (cnt == '0);
  assign noise_data  = busy ? lfsr : 16'h0;

endmodule

// File: doc/noise_arbiter.md
# noise_arbiter

Shares one 16-bit Fibonacci LFSR noise source among `NUM_REQ` requesters. Each requester asks for a burst of noise words. The block arbitrates round-robin, grants one requester at a time, and streams that requester's words over a valid/ready handshake. It also handles reseeding of the LFSR. It sits between the noise source and the noise consumers, such as channel impairment and dither blocks, and replaces free-running per-consumer generators.

## Interface
- `NUM_REQ`, 4: number of requesters, range 2..8.
- `LEN_W`, 8: width of each burst-length field.
- `SEED`, 16'hACE1: reset seed, and the substitute seed used whenever a zero seed is loaded.

- `clk` in 1: clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `req` in NUM_REQ: per-requester burst request, level-sensitive.
- `req_len` in NUM_REQ*LEN_W: field i sits at bits [i*LEN_W +: LEN_W]; value L requests L+1 words.
- `seed_load` in 1: request to reload the LFSR.
- `seed_val` in 16: new seed value.
- `noise_ready` in 1: consumer accepts the current word.
- `gnt` out NUM_REQ: one-hot grant, registered.
- `noise_valid` out 1: word available.
- `noise_data` out 16: current LFSR value.
- `noise_last` out 1: current word is the final word of the burst.
- `busy` out 1: high while in STREAM.

## Operation
- LFSR step: `lfsr <= {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}`.
  - Steps only on a transfer, i.e. `noise_valid && noise_ready`.
  - Never free-runs.
- FSM has two states.
- IDLE:
  - If `seed_load`=1: load `seed_val` into `lfsr`, or `SEED` if `seed_val`==0. No arbitration that cycle; seed load has priority over requests.
  - Else if any `req` bit is set: pick the winner by searching from `ptr+1` upward, modulo NUM_REQ. Latch `cnt <= req_len[winner]`, set `gnt` one-hot to the winner, set `ptr <= winner`, go to STREAM.
- STREAM:
  - `noise_valid`=1, `noise_data`=`lfsr`, `noise_last`=(`cnt`==0).
  - On each transfer: step `lfsr`. If `cnt`==0, clear `gnt` and go to IDLE; otherwise decrement `cnt`.
  - With `noise_ready`=0, all state holds, including data, `cnt`, and `last`.
- Requests during STREAM:
  - `req` changes during STREAM are ignored; the burst always completes its full length.
  - A requester still holding `req` after its burst is re-arbitrated normally. Round-robin prevents starvation.
- `seed_load` during STREAM is ignored and not queued.
- Reset values:
  - `lfsr`=`SEED`.
  - `ptr`=NUM_REQ-1, so requester 0 wins first.
  - `cnt`=0, state IDLE.
  - `gnt`=0, `noise_valid`=0, `noise_last`=0, `busy`=0.
  - `noise_data`=0: it is gated to 0 whenever `noise_valid`=0.

## Timing
- Grant latency: `req` sampled high in IDLE at edge t gives `gnt`, `busy`, and `noise_valid` high after edge t, i.e. one cycle.
- Throughput: with `noise_ready` held high, a burst of L+1 words takes exactly L+1 STREAM cycles.
- Gaps: at least one IDLE cycle separates consecutive bursts, so burst-to-burst period is L+2 cycles.
- `gnt` drops on the edge that completes the last transfer, together with `noise_valid` and `noise_last`.
- A seed load at edge t is reflected as the first word of any burst granted at edge t+1 or later.
- Reset mid-burst: all outputs drop to 0 asynchronously. After release, the next burst restarts from `SEED`, with requester 0 first.
- Width rules:
  - `cnt` is `LEN_W` bits; L=2^LEN_W−1 gives 2^LEN_W words.
  - `ptr` is clog2(NUM_REQ) bits and wraps from NUM_REQ-1 to 0.

## Test plan
- Reset state: assert `reset` → `gnt`=0, `noise_valid`=0, `busy`=0, `noise_data`=0. After release, `lfsr`=16'hACE1.
- Single burst:
  - Stimulus: `req`=4'b0001, `req_len[0]`=2, `noise_ready`=1.
  - Expected: `gnt`=0001 for 3 cycles. Data is 16'hACE1, 16'h59C3, 16'h B387, with `noise_last` only on the third word. Then one IDLE cycle.
- Contention:
  - Stimulus: `req`=4'b1111, all lengths 0, held high.
  - Expected: grant order 0,1,2,3,0,1; each grant lasts 1 cycle followed by 1 IDLE cycle.
- Backpressure:
  - Stimulus: burst of 4 words with `noise_ready` low for 3 cycles after the first word.
  - Expected: `noise_data` holds 16'h59C3 and `cnt` is unchanged for those 3 cycles; the burst still delivers exactly 4 distinct words.
- Reseed:
  - `seed_load`=1 with `seed_val`=0 in IDLE → first burst word is 16'hACE1.
  - `seed_val`=16'h1234 → first word is 16'h1234.
  - `seed_load` pulsed during STREAM → data sequence unaffected.
- Reset mid-burst: assert `reset` on the 2nd word of a 5-word burst → outputs clear immediately. The next burst starts at 16'hACE1 and is granted to requester 0.
